draw_vga_pipe: RTL and testbench

Parametrised, pipelined successor to the single-bullet Draw_VGA renderer. It turns the VGA beam position (CounterX/CounterY from the sync generator) plus game-object state into 1-bit R/G/B for the DAC pins. Versus the previous generation it adds:
- a configurable alien grid and bullet count;
- frame-boundary shadowing of all object state, so no tearing;
- a two-frame alien animation;
- a per-alien hit-flash timer.

---
 rtl/invaders_pkg.sv | 42 ++++
 rtl/box_hit.sv | 22 ++
 rtl/draw_vga_pipe.sv | 247 ++++++++++++++++++++++++
 tb/tb_draw_vga_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared screen geometry, field widths and colour encodings for the invaders renderer.
package invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;
  localparam int BEAM_W   = 10;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_BLACK   = 3'b000;
  localparam rgb_t RGB_WHITE   = 3'b111;
  localparam rgb_t RGB_GREEN   = 3'b010;
  localparam rgb_t RGB_MAGENTA = 3'b101;

  // Winning object class for one pixel after priority resolution.
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_ALIEN,
    SRC_PLAYER,
    SRC_FLASH,
    SRC_BULLET
  } pixSrc_t;

  function automatic rgb_t srcColour(input pixSrc_t src);
    rgb_t c;
    c = RGB_BLACK;
    case (src)
      SRC_BULLET, SRC_FLASH: c = RGB_WHITE;
      SRC_PLAYER:            c = RGB_GREEN;
      SRC_ALIEN:             c = RGB_MAGENTA;
      default:               c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/box_hit.sv
// Axis-aligned box test; negative offsets wrap to large unsigned values and miss.
module box_hit
  import invaders_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 8
) (
  input  logic [BEAM_W-1:0] px,
  input  logic [BEAM_W-1:0] py,
  input  logic [COL_W-1:0]  left,
  input  logic [ROW_W-1:0]  top,
  output logic              hit
);

  logic [10:0] dx;
  logic [10:0] dy;

  assign dx  = {1'b0, px} - {1'b0, left};
  assign dy  = {1'b0, py} - {2'b0, top};
  assign hit = (dx < 11'(W)) && (dy < 11'(H));

endmodule

// File: rtl/draw_vga_pipe.sv
// Two-stage pixel renderer: frame-shadowed object state, alien grid with animation
// and hit flash, bullets and player, priority-muxed into registered 1-bit RGB.
module draw_vga_pipe
  import invaders_pkg::*;
#(
  parameter int GRID_ROWS     = 5,
  parameter int GRID_COLS     = 10,
  parameter int NUM_BULLETS   = 4,
  parameter int ALIEN_W       = 12,
  parameter int ALIEN_H       = 8,
  parameter int ALIEN_PITCH_X = 16,
  parameter int ALIEN_PITCH_Y = 16,
  parameter int PLAYER_W      = 16,
  parameter int PLAYER_H      = 8,
  parameter int BULLET_W      = 2,
  parameter int BULLET_H      = 6,
  parameter int ANIM_FRAMES   = 30,
  parameter int FLASH_FRAMES  = 8
) (
  input  logic                                      Clk,
  input  logic                                      Reset,
  input  logic [GRID_ROWS*GRID_COLS-1:0]            Aliens_Grid,
  input  logic [ROW_W-1:0]                          AliensRow,
  input  logic [COL_W-1:0]                          AliensCol,
  input  logic [ROW_W-1:0]                          PlayerRow,
  input  logic [COL_W-1:0]                          PlayerCol,
  input  logic [ROW_W*NUM_BULLETS-1:0]              BulletRow,
  input  logic [COL_W*NUM_BULLETS-1:0]              BulletCol,
  input  logic [NUM_BULLETS-1:0]                    BulletExists,
  input  logic                                      HitPulse,
  input  logic [$clog2(GRID_ROWS*GRID_COLS)-1:0]    HitIndex,
  input  logic [BEAM_W-1:0]                         CounterX,
  input  logic [BEAM_W-1:0]                         CounterY,
  input  logic                                      inDisplayArea,
  output logic                                      R,
  output logic                                      G,
  output logic                                      B
);

  localparam int GRID_N  = GRID_ROWS * GRID_COLS;
  localparam int IDX_W   = $clog2(GRID_N);
  localparam int PX_SH   = $clog2(ALIEN_PITCH_X);
  localparam int PY_SH   = $clog2(ALIEN_PITCH_Y);
  localparam int ANIM_W  = $clog2(ANIM_FRAMES + 1);
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

  logic frameStart;
  assign frameStart = (CounterX == '0) && (CounterY == '0);

  logic [GRID_N-1:0]              gridSh;
  logic [ROW_W-1:0]               aliensRowSh;
  logic [COL_W-1:0]               aliensColSh;
  logic [ROW_W-1:0]               playerRowSh;
  logic [COL_W-1:0]               playerColSh;
  logic [ROW_W*NUM_BULLETS-1:0]   bulletRowSh;
  logic [COL_W*NUM_BULLETS-1:0]   bulletColSh;
  logic [NUM_BULLETS-1:0]         bulletExistsSh;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      gridSh         <= '0;
      aliensRowSh    <= '0;
      aliensColSh    <= '0;
      playerRowSh    <= '0;
      playerColSh    <= '0;
      bulletRowSh    <= '0;
      bulletColSh    <= '0;
      bulletExistsSh <= '0;
    end else if (frameStart) begin
      gridSh         <= Aliens_Grid;
      aliensRowSh    <= AliensRow;
      aliensColSh    <= AliensCol;
      playerRowSh    <= PlayerRow;
      playerColSh    <= PlayerCol;
      bulletRowSh    <= BulletRow;
      bulletColSh    <= BulletCol;
      bulletExistsSh <= BulletExists;
    end
  end

  // Pixel (0,0) must already see the new frame's state, so bypass the shadows there.
  logic [GRID_N-1:0]              gridEff;
  logic [ROW_W-1:0]               aliensRowEff;
  logic [COL_W-1:0]               aliensColEff;
  logic [ROW_W-1:0]               playerRowEff;
  logic [COL_W-1:0]               playerColEff;
  logic [ROW_W*NUM_BULLETS-1:0]   bulletRowEff;
  logic [COL_W*NUM_BULLETS-1:0]   bulletColEff;
  logic [NUM_BULLETS-1:0]         bulletExistsEff;

  assign gridEff         = frameStart ? Aliens_Grid  : gridSh;
  assign aliensRowEff    = frameStart ? AliensRow    : aliensRowSh;
  assign aliensColEff    = frameStart ? AliensCol    : aliensColSh;
  assign playerRowEff    = frameStart ? PlayerRow    : playerRowSh;
  assign playerColEff    = frameStart ? PlayerCol    : playerColSh;
  assign bulletRowEff    = frameStart ? BulletRow    : bulletRowSh;
  assign bulletColEff    = frameStart ? BulletCol    : bulletColSh;
  assign bulletExistsEff = frameStart ? BulletExists : bulletExistsSh;

  logic [ANIM_W-1:0]  animCnt;
  logic               animPhase;
  logic [FLASH_W-1:0] flashCnt;
  logic [IDX_W-1:0]   flashIdx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      animCnt   <= '0;
      animPhase <= 1'b0;
    end else if (frameStart) begin
      if (animCnt == ANIM_W'(ANIM_FRAMES - 1)) begin
        animCnt   <= '0;
        animPhase <= ~animPhase;
      end else begin
        animCnt <= animCnt + ANIM_W'(1);
      end
    end
  end

  // A new hit always takes precedence over the per-frame countdown.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      flashCnt <= '0;
      flashIdx <= '0;
    end else if (HitPulse) begin
      flashCnt <= FLASH_W'(FLASH_FRAMES);
      flashIdx <= HitIndex;
    end else if (frameStart && (flashCnt != '0)) begin
      flashCnt <= flashCnt - FLASH_W'(1);
    end
  end

  logic [10:0]      dx;
  logic [10:0]      dy;
  logic [10:0]      cellCol;
  logic [10:0]      cellRow;
  logic [PX_SH-1:0] subX;
  logic [PY_SH-1:0] subY;
  logic [IDX_W-1:0] cellIdx;
  logic             inCell;
  logic             aliveBit;
  logic             legMask;
  logic             alienHit;
  logic             flashHit;

  always_comb begin
    dx       = {1'b0, CounterX} - {1'b0, aliensColEff};
    dy       = {1'b0, CounterY} - {2'b0, aliensRowEff};
    cellCol  = dx >> PX_SH;
    cellRow  = dy >> PY_SH;
    subX     = dx[PX_SH-1:0];
    subY     = dy[PY_SH-1:0];
    cellIdx  = IDX_W'(cellRow * 11'(GRID_COLS) + cellCol);
    inCell   = !dx[10] && !dy[10]
               && (cellCol < 11'(GRID_COLS)) && (cellRow < 11'(GRID_ROWS))
               && (32'(subX) < ALIEN_W) && (32'(subY) < ALIEN_H);
    aliveBit = 1'b0;
    if (inCell) aliveBit = gridEff[cellIdx];
    // Phase 1 frame: outer two columns of the bottom two sprite rows are the legs gap.
    legMask  = animPhase && (32'(subY) >= ALIEN_H - 2)
               && ((32'(subX) < 2) || (32'(subX) >= ALIEN_W - 2));
    alienHit = inCell && aliveBit && !legMask;
    flashHit = inCell && (flashCnt != '0) && (cellIdx == flashIdx);
  end

  logic playerHit;

  box_hit #(
    .W(PLAYER_W),
    .H(PLAYER_H)
  ) uPlayerBox (
    .px  (CounterX),
    .py  (CounterY),
    .left(playerColEff),
    .top (playerRowEff),
    .hit (playerHit)
  );

  logic [NUM_BULLETS-1:0] bulletHitVec;

  for (genvar k = 0; k < NUM_BULLETS; k++) begin : gBullet
    logic boxHit;

    box_hit #(
      .W(BULLET_W),
      .H(BULLET_H)
    ) uBulletBox (
      .px  (CounterX),
      .py  (CounterY),
      .left(bulletColEff[COL_W*k +: COL_W]),
      .top (bulletRowEff[ROW_W*k +: ROW_W]),
      .hit (boxHit)
    );

    assign bulletHitVec[k] = boxHit && bulletExistsEff[k];
  end

  logic onScreen;
  assign onScreen = inDisplayArea && (CounterX < BEAM_W'(SCREEN_W)) && (CounterY < BEAM_W'(SCREEN_H));

  logic bulletQ;
  logic flashQ;
  logic playerQ;
  logic alienQ;
  logic displayQ;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bulletQ  <= 1'b0;
      flashQ   <= 1'b0;
      playerQ  <= 1'b0;
      alienQ   <= 1'b0;
      displayQ <= 1'b0;
    end else begin
      bulletQ  <= |bulletHitVec;
      flashQ   <= flashHit;
      playerQ  <= playerHit;
      alienQ   <= alienHit;
      displayQ <= onScreen;
    end
  end

  pixSrc_t pixSrc;
  rgb_t    pixColour;

  always_comb begin
    pixSrc = SRC_NONE;
    if (bulletQ)      pixSrc = SRC_BULLET;
    else if (flashQ)  pixSrc = SRC_FLASH;
    else if (playerQ) pixSrc = SRC_PLAYER;
    else if (alienQ)  pixSrc = SRC_ALIEN;
    if (!displayQ) pixSrc = SRC_NONE;
    pixColour = srcColour(pixSrc);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      R <= 1'b0;
      G <= 1'b0;
      B <= 1'b0;
    end else begin
      R <= pixColour.r;
      G <= pixColour.g;
      B <= pixColour.b;
    end
  end

endmodule

// File: tb/tb_draw_vga_pipe.sv
// Directed scoreboard bench for draw_vga_pipe: beam coordinates are driven directly,
// a frame tick is a single (0,0) cycle.
module tb_draw_vga_pipe;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] WHITE   = 3'b111;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] MAGENTA = 3'b101;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [49:0] aliensGrid = '0;
  logic [8:0]  aliensRow = '0;
  logic [9:0]  aliensCol = '0;
  logic [8:0]  playerRow = '0;
  logic [9:0]  playerCol = '0;
  logic [35:0] bulletRow = '0;
  logic [39:0] bulletCol = '0;
  logic [3:0]  bulletExists = '0;
  logic        hitPulse = 1'b0;
  logic [5:0]  hitIndex = '0;
  logic [9:0]  counterX = 10'd5;
  logic [9:0]  counterY = 10'd5;
  logic        inDisplayArea = 1'b0;
  logic        R, G, B;

  draw_vga_pipe dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Aliens_Grid  (aliensGrid),
    .AliensRow    (aliensRow),
    .AliensCol    (aliensCol),
    .PlayerRow    (playerRow),
    .PlayerCol    (playerCol),
    .BulletRow    (bulletRow),
    .BulletCol    (bulletCol),
    .BulletExists (bulletExists),
    .HitPulse     (hitPulse),
    .HitIndex     (hitIndex),
    .CounterX     (counterX),
    .CounterY     (counterY),
    .inDisplayArea(inDisplayArea),
    .R            (R),
    .G            (G),
    .B            (B)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         due;
    int         x;
    int         y;
    logic [2:0] exp;
  } sbEntry_t;

  sbEntry_t sb[$];
  sbEntry_t cur;
  int cycleCount = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge Clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed rgb=%b expected rgb=%b", tag, obs, exp);
    end
  endtask

  // Output for a pixel presented at cycle n is compared once two clock edges have passed.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].due <= cycleCount) begin
      cur = sb.pop_front();
      checkOutput($sformatf("pix(%0d,%0d)", cur.x, cur.y), {R, G, B}, cur.exp);
    end
  end

  task automatic applyStimulus(input int x, input int y, input logic disp, input logic hit);
    @(negedge Clk);
    counterX      = 10'(x);
    counterY      = 10'(y);
    inDisplayArea = disp;
    hitPulse      = hit;
  endtask

  task automatic expectPixel(input int x, input int y, input logic disp, input logic [2:0] exp);
    applyStimulus(x, y, disp, 1'b0);
    sb.push_back('{due: cycleCount + 2, x: x, y: y, exp: exp});
  endtask

  task automatic frameTick(input logic hit);
    applyStimulus(0, 0, 1'b0, hit);
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL drain: pending=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("resetState", {R, G, B}, BLACK);
    Reset = 1'b1;

    aliensGrid = {50{1'b1}};
    aliensRow  = 9'd40;
    aliensCol  = 10'd100;
    playerRow  = 9'd400;
    playerCol  = 10'd500;
    expectPixel(100, 40, 1'b1, BLACK);

    frameTick(1'b0);
    expectPixel(100, 40, 1'b1, MAGENTA);
    expectPixel(112, 40, 1'b1, BLACK);
    expectPixel(99, 40, 1'b1, BLACK);
    expectPixel(100, 39, 1'b1, BLACK);
    expectPixel(111, 47, 1'b1, MAGENTA);
    expectPixel(100, 48, 1'b1, BLACK);
    expectPixel(244, 104, 1'b1, MAGENTA);
    expectPixel(260, 40, 1'b1, BLACK);
    expectPixel(100, 120, 1'b1, BLACK);
    expectPixel(100, 40, 1'b0, BLACK);
    expectPixel(500, 400, 1'b1, GREEN);

    bulletRow[18 +: 9]  = 9'd150;
    bulletCol[20 +: 10] = 10'd200;
    bulletRow[0 +: 9]   = 9'd300;
    bulletCol[0 +: 10]  = 10'd300;
    bulletExists        = 4'b0100;
    playerRow           = 9'd150;
    playerCol           = 10'd196;
    expectPixel(200, 150, 1'b1, BLACK);
    frameTick(1'b0);
    expectPixel(200, 150, 1'b1, WHITE);
    expectPixel(201, 155, 1'b1, WHITE);
    expectPixel(197, 150, 1'b1, GREEN);
    expectPixel(202, 150, 1'b1, GREEN);
    expectPixel(200, 156, 1'b1, GREEN);
    expectPixel(212, 150, 1'b1, BLACK);
    expectPixel(200, 158, 1'b1, BLACK);
    expectPixel(300, 300, 1'b1, BLACK);

    aliensCol = 10'd120;
    expectPixel(100, 200, 1'b1, BLACK);
    expectPixel(100, 40, 1'b1, MAGENTA);
    frameTick(1'b0);
    expectPixel(100, 40, 1'b1, BLACK);
    expectPixel(120, 40, 1'b1, MAGENTA);

    aliensCol = 10'd100;
    playerRow = 9'd300;
    playerCol = 10'd630;
    frameTick(1'b0);
    expectPixel(639, 300, 1'b1, GREEN);
    expectPixel(629, 300, 1'b1, BLACK);
    expectPixel(0, 300, 1'b1, BLACK);

    aliensGrid[13] = 1'b0;
    hitIndex       = 6'd13;
    frameTick(1'b1);
    expectPixel(148, 56, 1'b1, WHITE);
    expectPixel(164, 56, 1'b1, MAGENTA);
    for (int f = 2; f <= 8; f++) begin
      frameTick(1'b0);
      expectPixel(148, 56, 1'b1, WHITE);
    end
    frameTick(1'b0);
    expectPixel(148, 56, 1'b1, BLACK);

    for (int t = 14; t <= 29; t++) frameTick(1'b0);
    expectPixel(100, 47, 1'b1, MAGENTA);
    frameTick(1'b0);
    expectPixel(100, 47, 1'b1, BLACK);
    expectPixel(111, 46, 1'b1, BLACK);
    expectPixel(102, 47, 1'b1, MAGENTA);
    expectPixel(148, 56, 1'b1, BLACK);
    expectPixel(102, 40, 1'b1, MAGENTA);
    drain();

    checkOutput("preReset", {R, G, B}, MAGENTA);
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1 checkOutput("asyncReset", {R, G, B}, BLACK);
    @(negedge Clk);
    Reset = 1'b1;
    expectPixel(102, 40, 1'b1, BLACK);
    expectPixel(100, 47, 1'b1, BLACK);
    frameTick(1'b0);
    expectPixel(100, 47, 1'b1, MAGENTA);
    expectPixel(102, 40, 1'b1, MAGENTA);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
